alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
- Downstream capture stage for the 64-bit function-style ALU (ROL/ROR/MAX/MIN/DIV/NOR, opcodes 0-5).
- Registers each combinational ALU result with its opcode into a small FIFO and computes the registered zero and illegal-opcode flags.
- Presents entries to the writeback consumer over a valid/ready handshake, decoupling ALU issue from writeback stalls.

Parameters:
- WIDTH, 64, data width of ALU result.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- OPW, 4, opcode width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  FIFO can accept an entry.
- in_opcode  input  OPW  opcode that produced in_result.
- in_result  input  WIDTH  ALU result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_opcode  output  OPW  head entry opcode.
- out_result  output  WIDTH  head entry result.
- out_zero  output  1  head result == 0.
- out_illegal  output  1  head opcode > 5 (ALU default path).
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release) clears:
  - read pointer, write pointer and count to 0;
  - all storage entries to 0;
  - out_valid to 0; in_ready to 1.
  - out_result, out_opcode, out_zero and out_illegal read as 0 while empty after reset.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). It is a pure function of registered count and does not depend on out_ready, so a full FIFO does not accept a write even if a pop happens the same cycle.
- out_valid = (count != 0). Outputs are driven from the entry at the read pointer; there is no fall-through bypass.
- Latency: an entry pushed in cycle N is visible with out_valid=1 in cycle N+1.
- Flags are computed at push time and stored with the entry:
  - zero = (in_result == 0);
  - illegal = (in_opcode > 5).
- Illegal entries are stored and delivered unchanged; illegal is a marker only.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update rules:
  - push only: +1;
  - pop only: -1;
  - both or neither: hold.
- Pop when empty: impossible because out_valid=0; no state change.
- Push when full: impossible because in_ready=0; in_result is dropped by protocol. The upstream stage must hold in_valid until in_ready.
- Head outputs are stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all entries immediately. out_valid falls asynchronously.

Optional Feature:
- Macro: ALU_RESULT_STATS_EN.
- When defined, adds outputs stat_pushes[31:0] and stat_zero[31:0]:
  - saturating counters of accepted pushes and of accepted pushes with zero=1;
  - reset to 0 by rst_n;
  - stick at 32'hFFFFFFFF when saturated.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then idle: count=0, out_valid=0, in_ready=1, out_result=0.
- Push one entry (opcode 5, result 64'h0) in cycle N, with out_ready=0:
  - cycle N+1: out_valid=1, out_zero=1, out_illegal=0, count=1.
  - Outputs hold until out_ready=1.
- Push 4 entries (results 1,2,3,4) with out_ready=0:
  - count=4, in_ready=0.
  - A 5th in_valid with result 5 is not accepted.
  - Drain then yields 1,2,3,4 in order with count returning to 0.
- Streaming with in_valid=1 and out_ready=1 every cycle for 10 results 10..19 after a 1-entry prefill:
  - count stays 1 and all values emerge in order.
  - Pointers wrap past DEPTH-1 without loss.
- Push opcode 4'd9 with result 64'h0:
  - out_illegal=1, out_zero=1, out_opcode=9.
- Assert rst_n=0 with count=3:
  - out_valid drops before the next clock edge; count=0.
  - After release, the first push is delivered correctly.
- With ALU_RESULT_STATS_EN, after 6 pushes of which 2 are zero: stat_pushes=6, stat_zero=2.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: capture stage behind the 64-bit ALU. Each accepted ALU
// result is stored with its opcode and two precomputed flags (zero and
// illegal-opcode) in a small FIFO. The head entry is presented to the
// writeback consumer over a valid/ready handshake.
// Optional build macro ALU_RESULT_STATS_EN adds saturating push/zero-push
// statistics counters (stat_pushes, stat_zero).
module alu_result_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   parameter int OPW   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OPW-1:0]           in_opcode,
   input  logic [WIDTH-1:0]         in_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPW-1:0]           out_opcode,
   output logic [WIDTH-1:0]         out_result,
   output logic                     out_zero,
   output logic                     out_illegal,
`ifdef ALU_RESULT_STATS_EN
   output logic [31:0]              stat_pushes,
   output logic [31:0]              stat_zero,
`endif
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Storage: one slot per entry, cleared on reset so an empty FIFO
   // reads as all-zero after reset.
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [OPW-1:0]   op_q   [DEPTH];
   logic             zero_q [DEPTH];
   logic             ill_q  [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic push;
   logic pop;
   logic in_zero;
   logic in_illegal;

   // Handshake status comes purely from registered occupancy; a full FIFO
   // refuses a write even if the head is popped in the same cycle.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   // Flags are evaluated once, at push time, and travel with the entry.
   assign in_zero    = (in_result == '0);
   assign in_illegal = (in_opcode > OPW'(5));

   // Head outputs come straight from the slot at the read pointer.
   assign out_result  = data_q[rd_ptr_q];
   assign out_opcode  = op_q[rd_ptr_q];
   assign out_zero    = zero_q[rd_ptr_q];
   assign out_illegal = ill_q[rd_ptr_q];

   // Next-state for pointers and occupancy; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         // Slot gi captures the incoming entry when it is the write target.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_q[gi] <= '0;
               op_q[gi]   <= '0;
               zero_q[gi] <= 1'b0;
               ill_q[gi]  <= 1'b0;
            end else if (push && (wr_ptr_q == PW'(gi))) begin
               data_q[gi] <= in_result;
               op_q[gi]   <= in_opcode;
               zero_q[gi] <= in_zero;
               ill_q[gi]  <= in_illegal;
            end
         end
      end
   endgenerate

`ifdef ALU_RESULT_STATS_EN
   logic [31:0] stat_pushes_q, stat_pushes_d;
   logic [31:0] stat_zero_q,   stat_zero_d;

   // Saturating counters: stick at all-ones instead of wrapping.
   always_comb begin
      stat_pushes_d = stat_pushes_q;
      stat_zero_d   = stat_zero_q;
      if (push && (stat_pushes_q != 32'hFFFF_FFFF)) begin
         stat_pushes_d = stat_pushes_q + 32'd1;
      end
      if (push && in_zero && (stat_zero_q != 32'hFFFF_FFFF)) begin
         stat_zero_d = stat_zero_q + 32'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pushes_q <= '0;
         stat_zero_q   <= '0;
      end else begin
         stat_pushes_q <= stat_pushes_d;
         stat_zero_q   <= stat_zero_d;
      end
   end

   assign stat_pushes = stat_pushes_q;
   assign stat_zero   = stat_zero_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Testbench for alu_result_fifo: directed test-plan sequences followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_alu_result_fifo;

   localparam int WIDTH = 64;
   localparam int DEPTH = 4;
   localparam int OPW   = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [OPW-1:0]   in_opcode;
   logic [WIDTH-1:0] in_result;
   logic             out_valid;
   logic             out_ready;
   logic [OPW-1:0]   out_opcode;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_illegal;
   logic [2:0]       count;
`ifdef ALU_RESULT_STATS_EN
   logic [31:0]      stat_pushes;
   logic [31:0]      stat_zero;
`endif

   alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_opcode   (in_opcode),
      .in_result   (in_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_opcode  (out_opcode),
      .out_result  (out_result),
      .out_zero    (out_zero),
      .out_illegal (out_illegal),
`ifdef ALU_RESULT_STATS_EN
      .stat_pushes (stat_pushes),
      .stat_zero   (stat_zero),
`endif
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [OPW-1:0]   op;
      logic [WIDTH-1:0] res;
   } ent_t;

   ent_t        model_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned m_pushes = 0;
   int unsigned m_zero   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every visible output against the model's view of the FIFO.
   task automatic check_outputs();
      check_val("count", 64'(count), 64'(model_q.size()));
      check_val("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      check_val("in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
      if (model_q.size() != 0) begin
         check_val("out_result", out_result, model_q[0].res);
         check_val("out_opcode", 64'(out_opcode), 64'(model_q[0].op));
         check_val("out_zero", 64'(out_zero), 64'(model_q[0].res == 0));
         check_val("out_illegal", 64'(out_illegal), 64'(model_q[0].op > 5));
      end
`ifdef ALU_RESULT_STATS_EN
      check_val("stat_pushes", 64'(stat_pushes), 64'(m_pushes));
      check_val("stat_zero", 64'(stat_zero), 64'(m_zero));
`endif
   endtask

   // One clock with the currently driven inputs; model follows the
   // handshake rules, then outputs are sampled 1 time unit after the edge.
   task automatic cycle();
      bit   do_push;
      bit   do_pop;
      ent_t e;
      do_push = in_valid && (model_q.size() != DEPTH);
      do_pop  = out_ready && (model_q.size() != 0);
      e.op  = in_opcode;
      e.res = in_result;
      @(posedge clk);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
         model_q.push_back(e);
         m_pushes++;
         if (e.res == 0) m_zero++;
      end
      #1;
      $display("cycle push=%0b pop=%0b op=%0d res=%0h count=%0d", do_push, do_pop, e.op, e.res, count);
      check_outputs();
   endtask

   task automatic drive(input logic v, input logic [OPW-1:0] op, input logic [WIDTH-1:0] res, input logic rdy);
      in_valid  = v;
      in_opcode = op;
      in_result = res;
      out_ready = rdy;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      #12;
      // Reset state visible while reset is asserted and after release.
      check_val("rst_count", 64'(count), 64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      check_val("rst_out_result", out_result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      cycle();
      check_val("idle_out_result", out_result, 64'd0);
      check_val("idle_out_opcode", 64'(out_opcode), 64'd0);

      // Single zero-result push, held until out_ready.
      drive(1'b1, 4'd5, 64'h0, 1'b0);
      cycle();
      check_val("one_zero", 64'(out_zero), 64'd1);
      check_val("one_illegal", 64'(out_illegal), 64'd0);
      drive(1'b0, '0, '0, 1'b0);
      cycle();
      cycle();
      check_val("hold_valid", 64'(out_valid), 64'd1);
      drive(1'b0, '0, '0, 1'b1);
      cycle();

      // Fill to capacity, attempt a fifth write, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 4'd2, 64'(i), 1'b0);
         cycle();
      end
      check_val("full_count", 64'(count), 64'd4);
      check_val("full_in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 4'd2, 64'd5, 1'b0);
      cycle();
      check_val("full_no_accept", 64'(count), 64'd4);
      drive(1'b1, 4'd2, 64'd5, 1'b1);
      cycle();
      check_val("full_pop_no_push", 64'(count), 64'd3);
      drive(1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 4; i++) cycle();
      check_val("drained", 64'(count), 64'd0);

      // Streaming after a one-entry prefill: occupancy stays at one.
      drive(1'b1, 4'd1, 64'd9, 1'b0);
      cycle();
      for (int i = 10; i <= 19; i++) begin
         drive(1'b1, 4'd1, 64'(i), 1'b1);
         cycle();
         check_val("stream_count", 64'(count), 64'd1);
      end
      drive(1'b0, '0, '0, 1'b1);
      cycle();

      // Illegal opcode with zero result is stored and delivered as-is.
      drive(1'b1, 4'd9, 64'h0, 1'b0);
      cycle();
      check_val("ill_flag", 64'(out_illegal), 64'd1);
      check_val("ill_zero", 64'(out_zero), 64'd1);
      check_val("ill_opcode", 64'(out_opcode), 64'd9);
      drive(1'b0, '0, '0, 1'b1);
      cycle();

      // Asynchronous reset with three entries held.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd3, 64'(32'hA0 + i), 1'b0);
         cycle();
      end
      check_val("pre_rst_count", 64'(count), 64'd3);
      drive(1'b0, '0, '0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_val("async_out_valid", 64'(out_valid), 64'd0);
      check_val("async_count", 64'(count), 64'd0);
      model_q.delete();
      m_pushes = 0;
      m_zero   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 4'd0, 64'hDEAD_BEEF_0123_4567, 1'b0);
      cycle();
      check_val("post_rst_result", out_result, 64'hDEAD_BEEF_0123_4567);
      drive(1'b0, '0, '0, 1'b1);
      cycle();

      // Six pushes, two with zero result, for the statistics counters.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 4'd4, (i == 1 || i == 4) ? 64'd0 : 64'(i + 100), 1'b1);
         cycle();
      end
`ifdef ALU_RESULT_STATS_EN
      check_val("stat6_pushes", 64'(stat_pushes), 64'd7);
      check_val("stat6_zero", 64'(stat_zero), 64'd2);
`endif
      drive(1'b0, '0, '0, 1'b1);
      cycle();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic [WIDTH-1:0] r;
         r = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), r,
               ($urandom_range(0, 2) != 0));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
